// File: rtl/muldiv_issue_sched_if.sv
// Handshake bundle between the mul/div RS entry array, the scheduler and the shared datapath units.
// master = RS/datapath side, slave = scheduler side.
interface muldiv_issue_sched_if #(
   parameter int unsigned RS_COUNT = 8
) ();
   localparam int unsigned IDX_W = $clog2(RS_COUNT);

   logic                branch_mispredicted;
   logic [RS_COUNT-1:0] entry_rdy;
   logic [RS_COUNT-1:0] entry_is_div;
   logic                mul_done;
   logic                div_done;
   logic                wb_ready;

   logic                mul_start;
   logic [IDX_W-1:0]    mul_idx;
   logic                div_start;
   logic [IDX_W-1:0]    div_idx;
   logic [RS_COUNT-1:0] issue_ack;
   logic                wb_valid;
   logic                wb_is_div;
   logic [IDX_W-1:0]    wb_idx;
   logic                mul_err;
   logic                div_err;

   modport master (
      output branch_mispredicted, entry_rdy, entry_is_div, mul_done, div_done, wb_ready,
      input  mul_start, mul_idx, div_start, div_idx, issue_ack,
      input  wb_valid, wb_is_div, wb_idx, mul_err, div_err
   );

   modport slave (
      input  branch_mispredicted, entry_rdy, entry_is_div, mul_done, div_done, wb_ready,
      output mul_start, mul_idx, div_start, div_idx, issue_ack,
      output wb_valid, wb_is_div, wb_idx, mul_err, div_err
   );
endinterface

// File: rtl/muldiv_issue_sched.sv
// Issue scheduler for the shared multiplier/divider: round-robin issue, watchdogs, single CDB writeback port.
// Optional MULDIV_STALL_CNT_EN adds per-unit stall counters (mul_stall_cnt, div_stall_cnt).
module muldiv_issue_sched #(
   parameter int unsigned RS_COUNT   = 8,
   parameter int unsigned MUL_MAXCYC = 40,
   parameter int unsigned DIV_MAXCYC = 40
) (
   input  logic               clk,
   input  logic               rst,
   muldiv_issue_sched_if.slave bus
`ifdef MULDIV_STALL_CNT_EN
   ,
   output logic [31:0]        mul_stall_cnt,
   output logic [31:0]        div_stall_cnt
`endif
);
   localparam int unsigned IDX_W   = $clog2(RS_COUNT);
   localparam int unsigned MAX_CYC = (MUL_MAXCYC > DIV_MAXCYC) ? MUL_MAXCYC : DIV_MAXCYC;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] MUL_LIM = CNT_W'(MUL_MAXCYC);
   localparam logic [CNT_W-1:0] DIV_LIM = CNT_W'(DIV_MAXCYC);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} unit_st_e;

   // Index 0 is the multiplier, index 1 the divider throughout.
   unit_st_e                    st_q [2];
   logic [1:0][IDX_W-1:0]       rr_q;
   logic [1:0][IDX_W-1:0]       idx_q;
   logic [1:0][CNT_W-1:0]       cnt_q;
   logic [1:0]                  err_q;
   logic                        wb_prio_q;

   logic [1:0][RS_COUNT-1:0]    cand;
   logic [1:0][IDX_W-1:0]       grant;
   logic [1:0]                  found;
   logic [1:0]                  start_c;
   logic [RS_COUNT-1:0]         ack_c;
   logic [1:0]                  done_in;
   logic [1:0]                  pend;
   logic                        dual;
   logic                        wb_sel;
   logic                        wb_valid_c;
   logic                        wb_fire;
   logic                        flush;

   // First set bit of cand at or after ptr (wrapping); MSB of the result flags a hit.
   function automatic logic [IDX_W:0] rr_pick(input logic [RS_COUNT-1:0] c, input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] k;
      logic [IDX_W:0]   res;
      res = '0;
      for (int i = int'(RS_COUNT) - 1; i >= 0; i--) begin
         k = ptr + IDX_W'(i);
         if (c[k]) res = {1'b1, k};
      end
      return res;
   endfunction

   assign flush   = bus.branch_mispredicted;
   assign done_in = {bus.div_done, bus.mul_done};

   always_comb begin
      cand[0] = bus.entry_rdy & ~bus.entry_is_div;
      cand[1] = bus.entry_rdy &  bus.entry_is_div;
      ack_c   = '0;
      found   = '0;
      grant   = '0;
      start_c = '0;
      for (int u = 0; u < 2; u++) begin
         {found[u], grant[u]} = rr_pick(cand[u], rr_q[u]);
         start_c[u] = (st_q[u] == ST_IDLE) && found[u] && !flush;
         if (start_c[u]) ack_c[grant[u]] = 1'b1;
      end
   end

   // Writeback arbitration: wb_prio only matters when both results are waiting.
   assign pend       = {st_q[1] == ST_DONE, st_q[0] == ST_DONE};
   assign dual       = &pend;
   assign wb_sel     = dual ? wb_prio_q : pend[1];
   assign wb_valid_c = (|pend) && !flush;
   assign wb_fire    = wb_valid_c && bus.wb_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int u = 0; u < 2; u++) st_q[u] <= ST_IDLE;
         rr_q      <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         err_q     <= '0;
         wb_prio_q <= 1'b0;
      end else begin
         if (wb_fire && dual) wb_prio_q <= ~wb_prio_q;
         for (int u = 0; u < 2; u++) begin
            unique case (st_q[u])
               ST_IDLE: begin
                  if (start_c[u]) begin
                     st_q[u]  <= ST_BUSY;
                     idx_q[u] <= grant[u];
                     rr_q[u]  <= grant[u] + IDX_W'(1);
                     cnt_q[u] <= '0;
                  end
               end
               ST_BUSY: begin
                  if (flush) begin
                     st_q[u] <= ST_IDLE;
                  end else if (done_in[u]) begin
                     st_q[u] <= ST_DONE;
                  end else if ((cnt_q[u] + CNT_W'(1)) == ((u == 0) ? MUL_LIM : DIV_LIM)) begin
                     err_q[u] <= 1'b1;
                     st_q[u]  <= ST_IDLE;
                  end else begin
                     cnt_q[u] <= cnt_q[u] + CNT_W'(1);
                  end
               end
               ST_DONE: begin
                  if (flush || (wb_fire && (wb_sel == 1'(u)))) st_q[u] <= ST_IDLE;
               end
               default: st_q[u] <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.mul_start = start_c[0];
   assign bus.div_start = start_c[1];
   assign bus.issue_ack = ack_c;
   assign bus.mul_idx   = idx_q[0];
   assign bus.div_idx   = idx_q[1];
   assign bus.wb_valid  = wb_valid_c;
   assign bus.wb_is_div = wb_sel;
   assign bus.wb_idx    = idx_q[wb_sel];
   assign bus.mul_err   = err_q[0];
   assign bus.div_err   = err_q[1];

`ifdef MULDIV_STALL_CNT_EN
   logic [1:0][31:0] stall_q;

   // Counts cycles a ready entry of the unit's type waits behind a non-idle unit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         for (int u = 0; u < 2; u++) begin
            if ((|cand[u]) && (st_q[u] != ST_IDLE) && (stall_q[u] != 32'hFFFF_FFFF))
               stall_q[u] <= stall_q[u] + 32'd1;
         end
      end
   end

   assign mul_stall_cnt = stall_q[0];
   assign div_stall_cnt = stall_q[1];
`endif
endmodule

// File: tb/tb_muldiv_issue_sched.sv
// Self-checking bench for muldiv_issue_sched: directed scenarios plus a randomized run against a queue-level model.
module tb_muldiv_issue_sched;
   localparam int unsigned N     = 8;
   localparam int unsigned IDX_W = 3;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   muldiv_issue_sched_if #(.RS_COUNT(N)) bus ();

`ifdef MULDIV_STALL_CNT_EN
   logic [31:0] mul_stall_cnt;
   logic [31:0] div_stall_cnt;
   muldiv_issue_sched #(.RS_COUNT(N), .MUL_MAXCYC(40), .DIV_MAXCYC(40)) dut (
      .clk(clk), .rst(rst), .bus(bus), .mul_stall_cnt(mul_stall_cnt), .div_stall_cnt(div_stall_cnt));
`else
   muldiv_issue_sched #(.RS_COUNT(N), .MUL_MAXCYC(40), .DIV_MAXCYC(40)) dut (
      .clk(clk), .rst(rst), .bus(bus));
`endif

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.branch_mispredicted = 1'b0;
      bus.entry_rdy           = '0;
      bus.entry_is_div        = '0;
      bus.mul_done            = 1'b0;
      bus.div_done            = 1'b0;
      bus.wb_ready            = 1'b0;
   endtask

   task automatic do_reset();
      drive_idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] outs;
      drive_idle();
      rst = 1'b1;
      #3;
      outs = 32'({bus.mul_start, bus.div_start, bus.issue_ack, bus.wb_valid, bus.wb_is_div,
                  bus.wb_idx, bus.mul_idx, bus.div_idx, bus.mul_err, bus.div_err});
      checks++; if (outs !== 32'd0) begin failures++; $display("FAIL reset_outputs got=%0h exp=0", outs); end
      cyc(); cyc(); rst = 1'b0;
      // async reset in the middle of a multiply
      bus.entry_rdy = 8'h20; #3;
      checks++; if (bus.issue_ack !== 8'h20) begin failures++; $display("FAIL rst_issue_ack got=%0h exp=20", bus.issue_ack); end
      cyc(); bus.entry_rdy = '0; #3;
      checks++; if (bus.mul_idx !== 3'd5) begin failures++; $display("FAIL rst_mul_idx got=%0d exp=5", bus.mul_idx); end
      cyc(); #2; rst = 1'b1; #1;
      checks++; if (bus.mul_idx !== 3'd0) begin failures++; $display("FAIL async_rst_idx got=%0d exp=0", bus.mul_idx); end
      cyc(); rst = 1'b0; bus.mul_done = 1'b1; #3;
      checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL rst_stale_done got=%0b exp=0", bus.wb_valid); end
      cyc(); #3;
      checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL rst_stale_done2 got=%0b exp=0", bus.wb_valid); end
      drive_idle();
   endtask

   task automatic test_single_mul();
      do_reset();
      bus.entry_rdy = 8'h04; #3;
      checks++; if (bus.mul_start !== 1'b1) begin failures++; $display("FAIL single_start got=%0b exp=1", bus.mul_start); end
      checks++; if (bus.issue_ack !== 8'h04) begin failures++; $display("FAIL single_ack got=%0h exp=04", bus.issue_ack); end
      checks++; if (bus.div_start !== 1'b0) begin failures++; $display("FAIL single_div_start got=%0b exp=0", bus.div_start); end
      cyc(); bus.entry_rdy = '0; #3;
      checks++; if (bus.mul_idx !== 3'd2) begin failures++; $display("FAIL single_mul_idx got=%0d exp=2", bus.mul_idx); end
      checks++; if (bus.mul_start !== 1'b0) begin failures++; $display("FAIL single_no_restart got=%0b exp=0", bus.mul_start); end
      repeat (32) cyc();
      bus.mul_done = 1'b1; #3;
      checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL single_early_wb got=%0b exp=0", bus.wb_valid); end
      cyc(); #3;
      checks++; if ({bus.wb_valid, bus.wb_is_div, bus.wb_idx} !== 5'b10_010) begin
         failures++; $display("FAIL single_wb got=%0b exp=10010", {bus.wb_valid, bus.wb_is_div, bus.wb_idx}); end
      bus.wb_ready = 1'b1;
      cyc(); bus.wb_ready = 1'b0; bus.entry_rdy = 8'h01; #3;
      checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL single_wb_drop got=%0b exp=0", bus.wb_valid); end
      checks++; if (bus.issue_ack !== 8'h01) begin failures++; $display("FAIL single_reissue got=%0h exp=01", bus.issue_ack); end
      checks++; if (bus.mul_err !== 1'b0) begin failures++; $display("FAIL single_err got=%0b exp=0", bus.mul_err); end
      cyc(); drive_idle();
   endtask

   task automatic test_parallel();
      do_reset();
      bus.entry_rdy = 8'h03; bus.entry_is_div = 8'h02; #3;
      checks++; if ({bus.mul_start, bus.div_start} !== 2'b11) begin
         failures++; $display("FAIL par_starts got=%0b exp=11", {bus.mul_start, bus.div_start}); end
      checks++; if (bus.issue_ack !== 8'h03) begin failures++; $display("FAIL par_ack got=%0h exp=03", bus.issue_ack); end
      cyc(); bus.entry_rdy = '0; bus.entry_is_div = '0; #3;
      checks++; if (bus.mul_idx !== 3'd0) begin failures++; $display("FAIL par_mul_idx got=%0d exp=0", bus.mul_idx); end
      checks++; if (bus.div_idx !== 3'd1) begin failures++; $display("FAIL par_div_idx got=%0d exp=1", bus.div_idx); end
   endtask

   task automatic test_rr_fairness();
      int          exp_i;
      logic [7:0]  exp_ack;
      do_reset();
      for (int it = 0; it < 4; it++) begin
         exp_i   = (it % 2 == 0) ? 0 : 7;
         exp_ack = 8'(1) << exp_i;
         bus.entry_rdy = 8'h81; #3;
         checks++; if (bus.issue_ack !== exp_ack) begin
            failures++; $display("FAIL rr_grant%0d got=%0h exp=%0h", it, bus.issue_ack, exp_ack); end
         cyc(); bus.entry_rdy = '0; bus.mul_done = 1'b1; #3;
         checks++; if (bus.mul_idx !== IDX_W'(exp_i)) begin
            failures++; $display("FAIL rr_idx%0d got=%0d exp=%0d", it, bus.mul_idx, exp_i); end
         cyc(); bus.wb_ready = 1'b1; #3;
         checks++; if (!(bus.wb_valid === 1'b1 && bus.wb_idx === IDX_W'(exp_i))) begin
            failures++; $display("FAIL rr_wb%0d got=%0b/%0d exp=1/%0d", it, bus.wb_valid, bus.wb_idx, exp_i); end
         cyc(); bus.wb_ready = 1'b0; bus.mul_done = 1'b0;
      end
   endtask

   task automatic test_dual_pending();
      do_reset();
      bus.entry_rdy = 8'h03; bus.entry_is_div = 8'h02;
      cyc(); bus.entry_rdy = '0; bus.entry_is_div = '0; bus.mul_done = 1'b1; bus.div_done = 1'b1;
      cyc();
      for (int k = 0; k < 3; k++) begin
         #3;
         checks++; if ({bus.wb_valid, bus.wb_is_div, bus.wb_idx} !== 5'b10_000) begin
            failures++; $display("FAIL dual_hold%0d got=%0b exp=10000", k, {bus.wb_valid, bus.wb_is_div, bus.wb_idx}); end
         cyc();
      end
      bus.wb_ready = 1'b1; #3;
      checks++; if ({bus.wb_is_div, bus.wb_idx} !== 4'b0_000) begin
         failures++; $display("FAIL dual_first got=%0b exp=0000", {bus.wb_is_div, bus.wb_idx}); end
      cyc(); #3;
      checks++; if ({bus.wb_valid, bus.wb_is_div, bus.wb_idx} !== 5'b11_001) begin
         failures++; $display("FAIL dual_second got=%0b exp=11001", {bus.wb_valid, bus.wb_is_div, bus.wb_idx}); end
      cyc(); bus.wb_ready = 1'b0; bus.mul_done = 1'b0; bus.div_done = 1'b0;
      bus.entry_rdy = 8'h30; bus.entry_is_div = 8'h20; #3;
      checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL dual_empty got=%0b exp=0", bus.wb_valid); end
      checks++; if (bus.issue_ack !== 8'h30) begin failures++; $display("FAIL dual_reissue got=%0h exp=30", bus.issue_ack); end
      cyc(); bus.entry_rdy = '0; bus.entry_is_div = '0; bus.mul_done = 1'b1; bus.div_done = 1'b1;
      cyc(); #3;
      checks++; if ({bus.wb_is_div, bus.wb_idx} !== 4'b1_101) begin
         failures++; $display("FAIL dual_prio_div got=%0b exp=1101", {bus.wb_is_div, bus.wb_idx}); end
      bus.wb_ready = 1'b1;
      cyc(); #3;
      checks++; if ({bus.wb_valid, bus.wb_is_div, bus.wb_idx} !== 5'b10_100) begin
         failures++; $display("FAIL dual_then_mul got=%0b exp=10100", {bus.wb_valid, bus.wb_is_div, bus.wb_idx}); end
      cyc(); drive_idle();
   endtask

   task automatic test_flush();
      do_reset();
      bus.entry_rdy = 8'h03; bus.entry_is_div = 8'h02;
      cyc(); bus.entry_rdy = '0; bus.entry_is_div = '0; bus.mul_done = 1'b1;
      cyc(); bus.branch_mispredicted = 1'b1; bus.wb_ready = 1'b1; #3;
      checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL flush_wb got=%0b exp=0", bus.wb_valid); end
      cyc(); bus.branch_mispredicted = 1'b0; bus.wb_ready = 1'b0; bus.div_done = 1'b1; #3;
      checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL flush_idle got=%0b exp=0", bus.wb_valid); end
      cyc(); #3;
      checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL flush_stale got=%0b exp=0", bus.wb_valid); end
      cyc(); bus.branch_mispredicted = 1'b1; bus.entry_rdy = 8'h03; #3;
      checks++; if ({bus.mul_start, bus.issue_ack} !== 9'd0) begin
         failures++; $display("FAIL flush_no_issue got=%0h exp=0", {bus.mul_start, bus.issue_ack}); end
      cyc(); bus.branch_mispredicted = 1'b0; #3;
      checks++; if (bus.issue_ack !== 8'h02) begin failures++; $display("FAIL flush_rr_kept got=%0h exp=02", bus.issue_ack); end
      cyc(); drive_idle();
   endtask

   task automatic test_watchdog();
      do_reset();
      bus.entry_rdy = 8'h01; bus.entry_is_div = 8'h01; #3;
      checks++; if (bus.div_start !== 1'b1) begin failures++; $display("FAIL wd_start got=%0b exp=1", bus.div_start); end
      cyc(); bus.entry_rdy = '0; bus.entry_is_div = '0;
      repeat (39) cyc();
      #3;
      checks++; if (bus.div_err !== 1'b0) begin failures++; $display("FAIL wd_early got=%0b exp=0", bus.div_err); end
      cyc(); bus.entry_rdy = 8'h02; bus.entry_is_div = 8'h02; #3;
      checks++; if (bus.div_err !== 1'b1) begin failures++; $display("FAIL wd_fire got=%0b exp=1", bus.div_err); end
      checks++; if (bus.issue_ack !== 8'h02) begin failures++; $display("FAIL wd_reissue got=%0h exp=02", bus.issue_ack); end
      checks++; if (bus.mul_err !== 1'b0) begin failures++; $display("FAIL wd_mul_err got=%0b exp=0", bus.mul_err); end
      cyc(); bus.entry_rdy = '0; bus.entry_is_div = '0; #3;
      checks++; if ({bus.div_err, bus.div_idx} !== 4'b1_001) begin
         failures++; $display("FAIL wd_sticky got=%0b exp=1001", {bus.div_err, bus.div_idx}); end
      cyc(); drive_idle();
   endtask

   // Model: each unit either free (owner<0) or owns an entry; fin marks a result awaiting the CDB.
   task automatic test_random();
      int         owner [2];
      bit         fin [2];
      int         rr [2];
      int         dp_rem [2];
      bit         dp_done [2];
      bit         e_start [2];
      int         e_grant [2];
      bit         prio;
      bit         fl, wbr, e_valid, fire;
      int         e_sel, j;
      logic [N-1:0] rdy, typ, held, e_ack;
      do_reset();
      owner = '{-1, -1}; fin = '{0, 0}; rr = '{0, 0}; dp_rem = '{0, 0}; dp_done = '{0, 0};
      prio = 1'b0; rdy = '0; typ = '0; held = '0;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < N; i++)
            if (!rdy[i] && !held[i] && $urandom_range(3) == 0) begin
               rdy[i] = 1'b1; typ[i] = 1'($urandom_range(1));
            end
         fl  = ($urandom_range(31) == 0);
         wbr = ($urandom_range(2) != 0);
         bus.entry_rdy = rdy; bus.entry_is_div = typ;
         bus.mul_done = dp_done[0]; bus.div_done = dp_done[1];
         bus.branch_mispredicted = fl; bus.wb_ready = wbr;
         #3;
         e_ack = '0;
         for (int u = 0; u < 2; u++) begin
            e_start[u] = 1'b0; e_grant[u] = 0;
            if (owner[u] < 0 && !fl)
               for (int k = 0; k < N; k++) begin
                  j = (rr[u] + k) % N;
                  if (!e_start[u] && rdy[j] && int'(typ[j]) == u) begin e_start[u] = 1'b1; e_grant[u] = j; end
               end
            if (e_start[u]) e_ack[e_grant[u]] = 1'b1;
         end
         e_sel   = (fin[0] && fin[1]) ? int'(prio) : int'(fin[1]);
         e_valid = (fin[0] || fin[1]) && !fl;
         checks++; if ({bus.mul_start, bus.div_start} !== {e_start[0], e_start[1]}) begin
            failures++; $display("FAIL rnd_start n=%0d got=%0b exp=%0b", n, {bus.mul_start, bus.div_start}, {e_start[0], e_start[1]}); end
         checks++; if (bus.issue_ack !== e_ack) begin
            failures++; $display("FAIL rnd_ack n=%0d got=%0h exp=%0h", n, bus.issue_ack, e_ack); end
         checks++; if (bus.wb_valid !== e_valid) begin
            failures++; $display("FAIL rnd_wb_valid n=%0d got=%0b exp=%0b", n, bus.wb_valid, e_valid); end
         if (e_valid) begin
            checks++; if ({bus.wb_is_div, bus.wb_idx} !== {1'(e_sel), IDX_W'(owner[e_sel])}) begin
               failures++; $display("FAIL rnd_wb n=%0d got=%0b/%0d exp=%0d/%0d", n, bus.wb_is_div, bus.wb_idx, e_sel, owner[e_sel]); end
         end
         if (owner[0] >= 0) begin
            checks++; if (bus.mul_idx !== IDX_W'(owner[0])) begin
               failures++; $display("FAIL rnd_mul_idx n=%0d got=%0d exp=%0d", n, bus.mul_idx, owner[0]); end
         end
         if (owner[1] >= 0) begin
            checks++; if (bus.div_idx !== IDX_W'(owner[1])) begin
               failures++; $display("FAIL rnd_div_idx n=%0d got=%0d exp=%0d", n, bus.div_idx, owner[1]); end
         end
         checks++; if ({bus.mul_err, bus.div_err} !== 2'b00) begin
            failures++; $display("FAIL rnd_err n=%0d got=%0b exp=00", n, {bus.mul_err, bus.div_err}); end
         fire = e_valid && wbr;
         if (fire && fin[0] && fin[1]) prio = !prio;
         for (int u = 0; u < 2; u++) begin
            if (owner[u] >= 0) begin
               if (fl || (fin[u] && fire && e_sel == u)) begin
                  held[owner[u]] = 1'b0; owner[u] = -1; fin[u] = 1'b0;
               end else if (!fin[u] && dp_done[u]) begin
                  fin[u] = 1'b1;
               end
            end else if (e_start[u]) begin
               owner[u] = e_grant[u]; rr[u] = (e_grant[u] + 1) % N;
               rdy[e_grant[u]] = 1'b0; held[e_grant[u]] = 1'b1;
            end
            if (e_start[u]) begin
               dp_rem[u] = $urandom_range(12, 1); dp_done[u] = 1'b0;
            end else if (dp_rem[u] > 0) begin
               dp_rem[u]--;
               if (dp_rem[u] == 0) dp_done[u] = 1'b1;
            end
         end
         cyc();
      end
      drive_idle();
   endtask

   initial begin
      drive_idle();
      rst = 1'b1;
      test_reset();
      test_single_mul();
      test_parallel();
      test_rr_fairness();
      test_dual_pending();
      test_flush();
      test_watchdog();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
